// File: rtl/btb_predictor.sv
// Tagged branch target buffer with saturating direction counters.
// Registered lookup, write-first update bypass, and a multi-cycle invalidate sweep.
module btb_predictor #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    input  logic            lk_stall,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            inv_all,
    output logic            busy
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] WEAK_T = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CMAX   = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] sweep_cnt, sweep_cnt_d;

    logic               valid_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [CNT_W-1:0]   cnt_q   [ENTRIES];
    logic [PC_W-1:0]    tgt_q   [ENTRIES];

    logic [INDEX_W-1:0] lk_idx, u_idx;
    logic [TAG_W-1:0]   lk_tag, u_tag;
    logic               unused_pc_bits;

    assign lk_idx = lk_pc[INDEX_W+1:2];
    assign lk_tag = lk_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign u_idx  = upd_pc[INDEX_W+1:2];
    assign u_tag  = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign unused_pc_bits = ^{lk_pc, upd_pc};

    // Update path: resolved branches are dropped while a sweep is running.
    logic            upd_en, u_hit, wr_en;
    logic [CNT_W-1:0] wr_cnt;
    logic [PC_W-1:0]  wr_tgt;

    assign upd_en = upd_valid && (state_q == IDLE);
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_cnt = cnt_q[u_idx];
        wr_tgt = tgt_q[u_idx];
        if (upd_en) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    if (cnt_q[u_idx] != CMAX) wr_cnt = cnt_q[u_idx] + CNT_W'(1);
                    wr_tgt = upd_target;
                end else if (cnt_q[u_idx] != '0) begin
                    wr_cnt = cnt_q[u_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                wr_en  = 1'b1;
                wr_cnt = WEAK_T;
                wr_tgt = upd_target;
            end
        end
    end

    // Lookup sees the entry as it will be after this cycle's update.
    logic             byp, e_valid, l_hit, l_taken;
    logic [TAG_W-1:0] e_tag;
    logic [CNT_W-1:0] e_cnt;
    logic [PC_W-1:0]  e_tgt, l_tgt;

    always_comb begin
        byp     = wr_en && (u_idx == lk_idx);
        e_valid = byp ? 1'b1   : valid_q[lk_idx];
        e_tag   = byp ? u_tag  : tag_q[lk_idx];
        e_cnt   = byp ? wr_cnt : cnt_q[lk_idx];
        e_tgt   = byp ? wr_tgt : tgt_q[lk_idx];
        l_hit   = e_valid && (e_tag == lk_tag) && (state_q == IDLE);
        l_taken = l_hit && e_cnt[CNT_W-1];
        l_tgt   = l_taken ? e_tgt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!lk_stall) begin
            pred_valid  <= lk_valid;
            pred_hit    <= lk_valid && l_hit;
            pred_taken  <= lk_valid && l_taken;
            pred_target <= lk_valid ? l_tgt : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else begin
            if (state_q == SWEEP) valid_q[sweep_cnt] <= 1'b0;
            if (wr_en) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                cnt_q[u_idx]   <= wr_cnt;
                tgt_q[u_idx]   <= wr_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sweep_cnt <= sweep_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt;
        case (state_q)
            IDLE: begin
                if (inv_all) begin
                    state_d     = SWEEP;
                    sweep_cnt_d = '0;
                end
            end
            SWEEP: begin
                if (inv_all) begin
                    sweep_cnt_d = '0;
                end else if (sweep_cnt == '1) begin
                    state_d     = IDLE;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt + INDEX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SWEEP);
    end
endmodule
